glyph_vram_writer: RTL and testbench

- Upstream stage of the 1-bit VRAM that the VGA scan path reads.
- Accepts character-draw requests over a valid/ready handshake and fetches the 8x16 glyph rows from a synchronous font ROM.
- Writes each pixel into the VRAM write port, one per cycle. Also provides a full-screen clear.
- Runs on the system clock; the VRAM is dual-port, so writes never stall the display side.

---
 rtl/glyph_vram_writer.sv | 175 +++++++++++++++++
 tb/tb_glyph_vram_writer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_vram_writer.sv
// Glyph-to-VRAM writer: fetches 8x16 font rows from a synchronous ROM and writes
// one pixel per cycle into the 1-bit VRAM write port; also performs full-screen clear.
module glyph_vram_writer #(
    parameter int unsigned GLYPH_W  = 8,
    parameter int unsigned GLYPH_H  = 16,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req_valid,
    output logic              Req_ready,
    input  logic [7:0]        Req_char,
    input  logic [9:0]        Req_x,
    input  logic [8:0]        Req_y,
    input  logic              Req_transparent,
    input  logic              Clear_req,
    output logic [11:0]       Font_addr,
    input  logic [GLYPH_W-1:0] Font_data,
    output logic              Vram_we,
    output logic [ADDR_W-1:0] Vram_addr,
    output logic              Vram_data,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned BIT_W  = $clog2(GLYPH_W);
    localparam int unsigned ROW_W  = $clog2(GLYPH_H);
    localparam int unsigned PX_W   = 11;
    localparam int unsigned PY_W   = 10;
    localparam int unsigned PIXELS = SCREEN_W * SCREEN_H;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH_WAIT = 3'd1;
    localparam logic [2:0] S_LATCH      = 3'd2;
    localparam logic [2:0] S_WRITE      = 3'd3;
    localparam logic [2:0] S_CLEAR      = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    logic [2:0]         state_q,  state_d;
    logic [7:0]         char_q,   char_d;
    logic [9:0]         x_q,      x_d;
    logic [8:0]         y_q,      y_d;
    logic               transp_q, transp_d;
    logic [ROW_W-1:0]   row_q,    row_d;
    logic [BIT_W-1:0]   bit_q,    bit_d;
    logic [GLYPH_W-1:0] line_q,   line_d;
    logic [ADDR_W-1:0]  clr_q,    clr_d;
    logic [11:0]        faddr_q,  faddr_d;

    logic [PX_W-1:0]    px;
    logic [PY_W-1:0]    py;
    logic               pixel;
    logic               in_bounds;

    assign Req_ready = (state_q == S_IDLE) && !Clear_req;
    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign Font_addr = faddr_q;

    // State and datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            char_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            transp_q <= 1'b0;
            row_q    <= '0;
            bit_q    <= '0;
            line_q   <= '0;
            clr_q    <= '0;
            faddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            char_q   <= char_d;
            x_q      <= x_d;
            y_q      <= y_d;
            transp_q <= transp_d;
            row_q    <= row_d;
            bit_q    <= bit_d;
            line_q   <= line_d;
            clr_q    <= clr_d;
            faddr_q  <= faddr_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        char_d   = char_q;
        x_d      = x_q;
        y_d      = y_q;
        transp_d = transp_q;
        row_d    = row_q;
        bit_d    = bit_q;
        line_d   = line_q;
        clr_d    = clr_q;
        faddr_d  = faddr_q;
        case (state_q)
            S_IDLE: begin
                // Clear wins over a concurrent draw request, which stays pending
                if (Clear_req) begin
                    clr_d   = '0;
                    state_d = S_CLEAR;
                end else if (Req_valid) begin
                    char_d   = Req_char;
                    x_d      = Req_x;
                    y_d      = Req_y;
                    transp_d = Req_transparent;
                    row_d    = '0;
                    faddr_d  = {Req_char, 4'd0};
                    state_d  = S_FETCH_WAIT;
                end
            end
            S_FETCH_WAIT: state_d = S_LATCH;
            S_LATCH: begin
                line_d  = Font_data;
                bit_d   = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                line_d = line_q << 1;
                bit_d  = bit_q + BIT_W'(1);
                if (bit_q == BIT_W'(GLYPH_W - 1)) begin
                    if (row_q == ROW_W'(GLYPH_H - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        faddr_d = {char_q, 4'(row_q + ROW_W'(1))};
                        state_d = S_FETCH_WAIT;
                    end
                end
            end
            S_CLEAR: begin
                clr_d = clr_q + ADDR_W'(1);
                if (clr_q == ADDR_W'(PIXELS - 1)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel position at full width so off-screen positions clip instead of wrapping
    assign pixel     = line_q[GLYPH_W-1];
    assign px        = PX_W'(x_q) + PX_W'(bit_q);
    assign py        = PY_W'(y_q) + PY_W'(row_q);
    assign in_bounds = (px < PX_W'(SCREEN_W)) && (py < PY_W'(SCREEN_H));

    // VRAM port decoded from registered state only
    always_comb begin
        Vram_we   = 1'b0;
        Vram_addr = '0;
        Vram_data = 1'b0;
        case (state_q)
            S_WRITE: begin
                Vram_we   = in_bounds && (!transp_q || pixel);
                Vram_addr = ADDR_W'(py) * ADDR_W'(SCREEN_W) + ADDR_W'(px);
                Vram_data = pixel;
            end
            S_CLEAR: begin
                Vram_we   = 1'b1;
                Vram_addr = clr_q;
                Vram_data = 1'b0;
            end
            default: begin
                Vram_we   = 1'b0;
                Vram_addr = '0;
                Vram_data = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_glyph_vram_writer.sv
// Directed bench for glyph_vram_writer: glyph draws, clipping, reset, back-to-back and
// clear (on a reduced-screen instance to keep the run short).
module tb_glyph_vram_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        req_valid, req_ready, req_transparent, clear_req;
    logic [7:0]  req_char, font_data;
    logic [9:0]  req_x;
    logic [8:0]  req_y;
    logic [11:0] font_addr;
    logic        vram_we, vram_data, busy, done;
    logic [18:0] vram_addr;

    logic        s_valid, s_ready, s_transparent, s_clear;
    logic [7:0]  s_char, s_font_data;
    logic [9:0]  s_x;
    logic [8:0]  s_y;
    logic [11:0] s_font_addr;
    logic        s_we, s_data, s_busy, s_done;
    logic [11:0] s_addr;

    glyph_vram_writer u_dut (
        .Clk(clk), .Rst_n(rst_n),
        .Req_valid(req_valid), .Req_ready(req_ready), .Req_char(req_char),
        .Req_x(req_x), .Req_y(req_y), .Req_transparent(req_transparent),
        .Clear_req(clear_req), .Font_addr(font_addr), .Font_data(font_data),
        .Vram_we(vram_we), .Vram_addr(vram_addr), .Vram_data(vram_data),
        .Busy(busy), .Done(done)
    );

    glyph_vram_writer #(.SCREEN_W(64), .SCREEN_H(48), .ADDR_W(12)) u_small (
        .Clk(clk), .Rst_n(rst_n),
        .Req_valid(s_valid), .Req_ready(s_ready), .Req_char(s_char),
        .Req_x(s_x), .Req_y(s_y), .Req_transparent(s_transparent),
        .Clear_req(s_clear), .Font_addr(s_font_addr), .Font_data(s_font_data),
        .Vram_we(s_we), .Vram_addr(s_addr), .Vram_data(s_data),
        .Busy(s_busy), .Done(s_done)
    );

    logic [7:0] rom [4096];
    always_ff @(posedge clk) begin
        font_data   <= rom[font_addr];
        s_font_data <= rom[s_font_addr];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Observed writes on the main instance, encoded as addr*2+data
    int got_q[$];
    int exp_q[$];
    always @(negedge clk) if (vram_we) got_q.push_back(int'(vram_addr) * 2 + int'(vram_data));

    // Clear-instance write counter and out-of-order/nonzero write counter
    int s_wr = 0;
    int s_bad = 0;
    always @(negedge clk) begin
        if (s_we) begin
            if (s_addr != 12'(s_wr) || s_data) s_bad++;
            s_wr++;
        end
    end

    task automatic build_exp(input logic [7:0] ch, input int x, input int y, input bit t);
        logic [7:0] line;
        exp_q.delete();
        for (int r = 0; r < 16; r++) begin
            line = rom[{ch, 4'(r)}];
            for (int b = 0; b < 8; b++) begin
                if ((x + b) < 640 && (y + r) < 480 && (!t || line[7-b]))
                    exp_q.push_back(((y + r) * 640 + (x + b)) * 2 + int'(line[7-b]));
            end
        end
    endtask

    task automatic cmp_seq(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, got_q[i], exp_q[i]);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Issue one draw; cycle 1 is the cycle right after the accept edge
    task automatic draw(input logic [7:0] ch, input int x, input int y, input bit t,
                        input bit hold, input logic [7:0] nxt, input string tag);
        int cyc;
        @(negedge clk);
        req_char = ch; req_x = 10'(x); req_y = 9'(y); req_transparent = t; req_valid = 1'b1;
        got_q.delete();
        build_exp(ch, x, y, t);
        #1 chk({tag, "_ready"}, req_ready, 1);
        @(posedge clk); #1;
        if (hold) req_char = nxt;
        else req_valid = 1'b0;
        req_x = 10'd3; req_y = 9'd7; req_transparent = ~t;
        chk({tag, "_faddr0"}, font_addr, {20'd0, ch, 4'h0});
        chk({tag, "_busy"}, busy, 1);
        wait_done(cyc);
        chk({tag, "_done_cyc"}, cyc, 161);
        req_x = 10'(x); req_y = 9'(y); req_transparent = t;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 4096; i++) rom[i] = 8'((i * 73) ^ (i >> 3) ^ 8'hA5);

        rst_n = 1'b0;
        req_valid = 0; req_char = 0; req_x = 0; req_y = 0; req_transparent = 0; clear_req = 0;
        s_valid = 0; s_char = 0; s_x = 0; s_y = 0; s_transparent = 0; s_clear = 0;
        #2;
        chk("rst_we", vram_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_faddr", font_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ready", req_ready, 1);

        // Opaque 'A' at origin
        draw(8'h41, 0, 0, 0, 0, 8'h00, "opaque");
        cmp_seq("opaque_seq");
        chk("opaque_first", got_q.size() > 0 ? got_q[0] : -1, int'(rom[12'h410][7]));
        @(posedge clk); #1;
        chk("opaque_ready_after", req_ready, 1);
        chk("opaque_idle", busy, 0);

        // Transparent 'A': foreground pixels only, same timing
        draw(8'h41, 0, 0, 1, 0, 8'h00, "transp");
        cmp_seq("transp_seq");
        @(posedge clk); #1;

        // Bottom-right clipping: 4 columns x 10 rows
        draw(8'h5A, 636, 470, 0, 0, 8'h00, "clip");
        cmp_seq("clip_seq");
        chk("clip_n", got_q.size(), 40);
        chk("clip_last", got_q.size() > 0 ? got_q[got_q.size()-1] / 2 : -1, 307199);
        @(posedge clk); #1;

        // Back-to-back with Req_valid held and Req_char changed while busy
        draw(8'h30, 200, 100, 0, 1, 8'h31, "b2b1");
        cmp_seq("b2b1_seq");
        @(posedge clk); #1;
        chk("b2b_gap_busy", busy, 0);
        chk("b2b_gap_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b2_busy", busy, 1);
        chk("b2b2_faddr0", font_addr, {8'h31, 4'h0});
        got_q.delete();
        build_exp(8'h31, 200, 100, 0);
        wait_done(cyc);
        chk("b2b2_done_cyc", cyc, 161);
        cmp_seq("b2b2_seq");
        @(posedge clk); #1;

        // Reset in cycle 50 of an opaque draw
        @(negedge clk);
        req_char = 8'h7E; req_x = 10'd100; req_y = 9'd100; req_transparent = 0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (49) @(posedge clk);
        #3;
        chk("mid_we_pre", vram_we, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", vram_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_faddr", font_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        draw(8'h42, 8, 16, 0, 0, 8'h00, "post_rst");
        cmp_seq("post_rst_seq");
        @(posedge clk); #1;

        // Clear with a concurrent request on the reduced-screen instance (64x48)
        @(negedge clk);
        s_wr = 0; s_bad = 0;
        s_clear = 1'b1; s_valid = 1'b1; s_char = 8'h41; s_x = 0; s_y = 0; s_transparent = 0;
        #1 chk("clr_ready_low", s_ready, 0);
        @(posedge clk); #1;
        s_clear = 1'b0;
        chk("clr_busy", s_busy, 1);
        cyc = 1;
        while (!s_done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("clr_done_cyc", cyc, 3073);
        chk("clr_writes", s_wr, 3072);
        chk("clr_bad", s_bad, 0);
        @(posedge clk); #1;
        chk("clr_idle_ready", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("held_busy", s_busy, 1);
        chk("held_faddr0", s_font_addr, {8'h41, 4'h0});
        cyc = 1;
        while (!s_done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("held_done_cyc", cyc, 161);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
